hazard_ctl: RTL and testbench

- Pipeline hazard controller. It is the counterpart of the forwarding unit, which resolves only M/W→E ALU operands and defers load-use to this block.
- Detects load-use dependencies between D and E, taken-branch redirects from E, and data-memory wait states in M.
- Drives the stall, bubble, flush and freeze controls of the F/D/E/M pipeline registers.
- Tracks memory-wait duration for a sticky timeout error and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/hazard_ctl_sat_counter.sv | 31 +++
 rtl/hazard_ctl.sv | 129 ++++++++++++
 tb/tb_hazard_ctl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard controller and the pipeline top.
//   hazard_state_t : memory-wait FSM states
//   reg_sel_t      : register index at the default index width
//   hazard_ctrl_t  : bundle of the five pipeline-register controls
package pipe_pkg;

  localparam int PIPE_REG_SELECT = 5;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hazard_state_t;

  typedef logic [PIPE_REG_SELECT-1:0] reg_sel_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic bubble_e;
    logic flush_d;
    logic freeze;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_ctl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en         : increment this edge (holds once MAX is reached)
//   clr        : synchronous clear, wins over en
//   count      : current value
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v >= MAX) ? MAX : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use stalls between D and E, taken-branch
// squash from E, and whole-pipeline freeze while the data memory in M waits.
// Also flags a sticky memory-wait timeout and counts stalled cycles.
//   i_reg_a/b_select_D, i_uses_a/b_D : D-stage sources and their use flags
//   i_is_load_E, i_reg_c_select_E    : E-stage load flag and destination
//   i_branch_taken_E                 : E-stage redirect
//   i_dmem_req_M, i_dmem_ready_M     : M-stage memory handshake
//   o_stall_F, o_stall_D, o_bubble_E, o_flush_D, o_freeze : combinational controls
//   o_mem_timeout                    : sticky error, cleared only by reset
//   o_stall_count                    : saturating count of stalled cycles
module hazard_ctl
  import pipe_pkg::*;
#(
  parameter int REG_SELECT         = 5,
  parameter int TIMEOUT_CYCLES     = 256,
  parameter int CNT_WIDTH          = 32,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_SELECT-1:0] i_reg_a_select_D,
  input  logic [REG_SELECT-1:0] i_reg_b_select_D,
  input  logic                  i_uses_a_D,
  input  logic                  i_uses_b_D,
  input  logic                  i_is_load_E,
  input  logic [REG_SELECT-1:0] i_reg_c_select_E,
  input  logic                  i_branch_taken_E,
  input  logic                  i_dmem_req_M,
  input  logic                  i_dmem_ready_M,
  output logic                  o_stall_F,
  output logic                  o_stall_D,
  output logic                  o_bubble_E,
  output logic                  o_flush_D,
  output logic                  o_freeze,
  output logic                  o_mem_timeout,
  output logic [CNT_WIDTH-1:0]  o_stall_count
);

  localparam int              WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  logic          mem_wait;
  logic          dest_ignored;
  logic          a_hit;
  logic          b_hit;
  logic          load_use;
  hazard_ctrl_t  ctrl;
  hazard_state_t state;
  logic [WAIT_W-1:0] wait_cnt;
  logic          any_stall;

  assign mem_wait = i_dmem_req_M & ~i_dmem_ready_M;

  // x0 is never written, so a load "to x0" creates no real dependency.
  assign dest_ignored = (ZERO_REG_HARDWIRED != 0) && (i_reg_c_select_E == '0);
  assign a_hit    = i_uses_a_D && (i_reg_a_select_D == i_reg_c_select_E);
  assign b_hit    = i_uses_b_D && (i_reg_b_select_D == i_reg_c_select_E);
  assign load_use = i_is_load_E && (a_hit || b_hit) && !dest_ignored;

  // Freeze dominates: frozen registers hold, so a pending branch or load-use
  // is simply re-evaluated once memory releases. A taken branch squashes D,
  // which makes any load-use match on that D instruction irrelevant.
  always_comb begin
    ctrl = '0;
    if (mem_wait) begin
      ctrl.freeze = 1'b1;
    end else if (i_branch_taken_E) begin
      ctrl.flush_d  = 1'b1;
      ctrl.bubble_e = 1'b1;
    end else if (load_use) begin
      ctrl.stall_f  = 1'b1;
      ctrl.stall_d  = 1'b1;
      ctrl.bubble_e = 1'b1;
    end
  end

  assign o_stall_F  = ctrl.stall_f;
  assign o_stall_D  = ctrl.stall_d;
  assign o_bubble_E = ctrl.bubble_e;
  assign o_flush_D  = ctrl.flush_d;
  assign o_freeze   = ctrl.freeze;
  assign any_stall  = ctrl.freeze | ctrl.stall_d | ctrl.bubble_e;

  // Leaving WAIT on any ~mem_wait, including a dropped request, keeps a
  // misbehaving memory from hanging the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (mem_wait)  state <= WAIT;
        WAIT:    if (!mem_wait) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Every frozen cycle counts, including the one that enters WAIT.
  sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_wait),
    .clr   ((state == WAIT) && !mem_wait),
    .count (wait_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_timeout <= 1'b0;
    end else if (wait_cnt == WAIT_MAX) begin
      o_mem_timeout <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH),
    .MAX   ({CNT_WIDTH{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (any_stall),
    .clr   (1'b0),
    .count (o_stall_count)
  );

endmodule

// File: tb/tb_hazard_ctl.sv
module tb_hazard_ctl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] a_sel, b_sel, c_sel;
  logic       uses_a, uses_b, is_load, br_taken, dreq, drdy;

  logic        stall_f, stall_d, bubble_e, flush_d, freeze, timeout;
  logic [31:0] cnt;
  logic        a_stall_f, a_stall_d, a_bubble_e, a_flush_d, a_freeze, a_timeout;
  logic [2:0]  a_cnt;

  always #5 clk = ~clk;

  hazard_ctl u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_reg_a_select_D(a_sel), .i_reg_b_select_D(b_sel),
    .i_uses_a_D(uses_a), .i_uses_b_D(uses_b),
    .i_is_load_E(is_load), .i_reg_c_select_E(c_sel),
    .i_branch_taken_E(br_taken),
    .i_dmem_req_M(dreq), .i_dmem_ready_M(drdy),
    .o_stall_F(stall_f), .o_stall_D(stall_d), .o_bubble_E(bubble_e),
    .o_flush_D(flush_d), .o_freeze(freeze),
    .o_mem_timeout(timeout), .o_stall_count(cnt)
  );

  // Alternate build: x0 not hardwired, short timeout, 3-bit stall counter.
  hazard_ctl #(
    .TIMEOUT_CYCLES(4), .CNT_WIDTH(3), .ZERO_REG_HARDWIRED(0)
  ) u_alt (
    .clk(clk), .rst_n(rst_n),
    .i_reg_a_select_D(a_sel), .i_reg_b_select_D(b_sel),
    .i_uses_a_D(uses_a), .i_uses_b_D(uses_b),
    .i_is_load_E(is_load), .i_reg_c_select_E(c_sel),
    .i_branch_taken_E(br_taken),
    .i_dmem_req_M(dreq), .i_dmem_ready_M(drdy),
    .o_stall_F(a_stall_f), .o_stall_D(a_stall_d), .o_bubble_E(a_bubble_e),
    .o_flush_D(a_flush_d), .o_freeze(a_freeze),
    .o_mem_timeout(a_timeout), .o_stall_count(a_cnt)
  );

  // exp bit order: {stall_F, stall_D, bubble_E, flush_D, freeze}
  typedef struct {
    logic [4:0] a, b;
    logic       ua, ub, ld;
    logic [4:0] c;
    logic       br, req, rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t       tbl[12];
  logic [4:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b,
                              input logic ua, input logic ub, input logic ld,
                              input logic [4:0] c, input logic br,
                              input logic req, input logic rdy,
                              input logic [4:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.ua = ua; v.ub = ub; v.ld = ld; v.c = c;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_sel = v.a; b_sel = v.b; uses_a = v.ua; uses_b = v.ub;
    is_load = v.ld; c_sel = v.c; br_taken = v.br; dreq = v.req; drdy = v.rdy;
    exp_q.push_back(v.exp);
  endtask

  task automatic check_ctrl(input string name);
    logic [4:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
    chk(name, {stall_f, stall_d, bubble_e, flush_d, freeze}, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive, check controls mid-cycle, advance one edge
  task automatic cycle(input vec_t v, input string name);
    drive(v);
    #2;
    check_ctrl(name);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, lu5, wt, rel;
    logic [31:0] base;
    int          n_stall;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    lu5  = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, 5'b11100);
    wt   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001);
    rel  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000);

    tbl[0]  = idle;
    tbl[1]  = lu5;
    tbl[2]  = mk(5, 5, 0, 0, 1, 5, 0, 0, 0, 5'b00000);
    tbl[3]  = mk(1, 5, 0, 1, 1, 5, 0, 0, 0, 5'b11100);
    tbl[4]  = mk(5, 0, 1, 0, 0, 5, 0, 0, 0, 5'b00000);
    tbl[5]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[6]  = mk(5, 0, 1, 0, 1, 5, 1, 0, 0, 5'b00110);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00110);
    tbl[8]  = mk(5, 0, 1, 0, 1, 5, 0, 1, 1, 5'b11100);
    tbl[9]  = mk(5, 0, 1, 0, 1, 5, 1, 1, 0, 5'b00001);
    tbl[10] = mk(7, 7, 0, 1, 1, 6, 0, 0, 0, 5'b00000);
    tbl[11] = idle;

    // reset state
    rst_n = 1'b0;
    drive(idle);
    #2;
    check_ctrl("reset_ctrl");
    chk("reset_timeout", timeout, 0);
    chk("reset_count", cnt, 0);
    chk("reset_state", u_dut.state, RUN);
    step();
    rst_n = 1'b1;

    // table-driven single-cycle vectors
    base = cnt;
    n_stall = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i], $sformatf("tbl[%0d]", i));
      if (tbl[i].exp[4] | tbl[i].exp[3] | tbl[i].exp[2] | tbl[i].exp[0]) n_stall++;
    end
    chk("tbl_stall_count", cnt, base + 32'(n_stall));

    // load-use: one bubble, then load in M gives no stall
    base = cnt;
    cycle(lu5, "lu_stall");
    cycle(mk(5, 0, 1, 0, 0, 5, 0, 0, 0, 5'b00000), "lu_next");
    chk("lu_count", cnt, base + 1);

    // x0 destination: ignored when hardwired, stalls otherwise
    drive(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 5'b00000));
    #2;
    check_ctrl("x0_hardwired");
    chk("x0_not_hardwired", {a_stall_f, a_stall_d, a_bubble_e, a_flush_d, a_freeze}, 5'b11100);
    step();
    cycle(idle, "x0_idle");

    // three wait cycles then ready
    base = cnt;
    for (int i = 0; i < 3; i++) begin
      cycle(wt, "wait_freeze");
      if (i == 0) chk("wait_state", u_dut.state, WAIT);
    end
    cycle(rel, "wait_release");
    chk("wait_count", cnt, base + 3);
    chk("wait_state_run", u_dut.state, RUN);

    // branch held in E across a wait flushes only on release
    base = cnt;
    for (int i = 0; i < 3; i++)
      cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00001), "br_wait");
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b00110), "br_release");
    cycle(idle, "br_after");
    chk("br_count", cnt, base + 4);

    // six wait cycles on the short-timeout build
    for (int i = 0; i < 6; i++) begin
      cycle(wt, "to_freeze");
      if (i == 2) chk("to_early", a_timeout, 0);
    end
    chk("to_set", a_timeout, 1);
    chk("to_main_clear", timeout, 0);
    cycle(idle, "to_release");
    chk("to_sticky", a_timeout, 1);

    // asynchronous reset in the middle of a wait
    cycle(wt, "rst_wait");
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_timeout", a_timeout, 0);
    chk("rst_count", cnt, 0);
    chk("rst_alt_count", a_cnt, 0);
    chk("rst_state", u_dut.state, RUN);
    exp_q.push_back(5'b00001);
    check_ctrl("rst_comb_follows");
    #1;
    rst_n = 1'b1;
    drive(idle);
    void'(exp_q.pop_back());
    step();

    // ten stalls saturate the 3-bit counter
    for (int i = 0; i < 10; i++) cycle(lu5, "sat_stall");
    chk("sat_alt_count", a_cnt, 7);
    chk("sat_main_count", cnt, 10);
    cycle(idle, "sat_idle");
    chk("sat_hold", a_cnt, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
